// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard
//   2-read/1-write register file with write-to-read bypass and a per-register
//   busy scoreboard. Decode marks a destination pending at issue; writeback
//   clears it. Reads are muxed, not tri-stated.
//
//   Optional feature macro: ZERO_REG_EN. When defined, register 0 is hardwired
//   to zero and never becomes busy.
//
// Ports
//   clk                    clock; all state updates on the rising edge
//   rst                    synchronous active-high reset
//   rd_addr1/2             read port register indices
//   rd_data1/2             read data, combinational, with writeback bypass
//   rd_busy1/2             selected register has a pending, unwritten result
//   wr_en/wr_addr/wr_data  writeback strobe, destination and data
//   iss_en/iss_addr        issue strobe and destination to mark busy
//   flush                  clear every busy bit
//   any_busy               registered OR of all busy bits
module reg_file_scoreboard #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] rd_addr1,
  output logic [WIDTH-1:0]         rd_data1,
  output logic                     rd_busy1,
  input  logic [$clog2(DEPTH)-1:0] rd_addr2,
  output logic [WIDTH-1:0]         rd_data2,
  output logic                     rd_busy2,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     iss_en,
  input  logic [$clog2(DEPTH)-1:0] iss_addr,
  input  logic                     flush,
  output logic                     any_busy
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             any_busy_q;

  // Next-state storage.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
`ifdef ZERO_REG_EN
    mem_d[0] = '0;
`endif
  end

  // Next-state busy: flush beats issue, issue beats a same-cycle writeback.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        busy_d[i] = 1'b0;
      end else if (iss_en && (iss_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
`ifdef ZERO_REG_EN
    busy_d[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q     <= '0;
      any_busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q     <= busy_d;
      // Reflects the current busy state, so it trails busy changes by a cycle.
      any_busy_q <= |busy_q;
    end
  end

  // Read ports. A matching writeback supplies the data now, so the register is
  // reported not busy even though busy_q still holds the old bit.
  logic byp1, byp2;

  always_comb begin
    byp1     = wr_en && (wr_addr == rd_addr1);
    byp2     = wr_en && (wr_addr == rd_addr2);
    rd_data1 = byp1 ? wr_data : mem_q[rd_addr1];
    rd_data2 = byp2 ? wr_data : mem_q[rd_addr2];
    rd_busy1 = byp1 ? 1'b0 : busy_q[rd_addr1];
    rd_busy2 = byp2 ? 1'b0 : busy_q[rd_addr2];
`ifdef ZERO_REG_EN
    if (rd_addr1 == '0) begin
      rd_data1 = '0;
      rd_busy1 = 1'b0;
    end
    if (rd_addr2 == '0) begin
      rd_data2 = '0;
      rd_busy2 = 1'b0;
    end
`endif
  end

  assign any_busy = any_busy_q;

endmodule
